// File: rtl/circle_pixel_render.sv
// Purpose: renders a coloured ring (or, with CIRCLE_FILL_EN defined, a filled disc) around a per-frame latched centre.
// Latency: 3 cycles from pix_valid to out_valid, one pixel per cycle.
// Backpressure: none; the pipeline always advances, and bubbles travel through as out_valid=0.
module circle_pixel_render #(
    parameter int Radius           = 150,
    parameter int Line_Width       = 3,
    parameter int Bit_Wight        = 10,
    parameter int Frames_Per_Color = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [Bit_Wight-1:0] Centre_X,
    input  logic [Bit_Wight-1:0] Centre_Y,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [Bit_Wight-1:0] pix_x,
    input  logic [Bit_Wight-1:0] pix_y,
    input  logic [1:0]           SW,
    output logic [3:0]           oRed,
    output logic [3:0]           oGreen,
    output logic [3:0]           oBlue,
    output logic                 out_valid
);

    localparam int DW  = Bit_Wight + 1;       // signed delta width
    localparam int SQW = 2 * DW;              // square width
    localparam int D2W = SQW + 1;             // sum-of-squares width
    localparam int FCW = (Frames_Per_Color > 1) ? $clog2(Frames_Per_Color) : 1;

    localparam logic [D2W-1:0] R_OUT_SQ = D2W'(Radius * Radius);
    localparam logic [D2W-1:0] R_IN_SQ  = D2W'((Radius - Line_Width) * (Radius - Line_Width));
    localparam logic [Bit_Wight-1:0] CENTRE_RST = Bit_Wight'(Radius + Line_Width);
    localparam logic [FCW-1:0] FC_LAST = FCW'(Frames_Per_Color - 1);

    typedef enum logic [1:0] {
        ST_RED   = 2'd0,
        ST_GREEN = 2'd1,
        ST_BLUE  = 2'd2
    } colour_t;

    colour_t state, state_nxt;
    logic [FCW-1:0]       frame_cnt;
    logic                 cnt_wrap;
    logic [Bit_Wight-1:0] cx, cy;

    logic                 v1, v2;
    logic [DW-1:0]        dx_s1, dy_s1;
    logic [SQW-1:0]       sq_x_s2, sq_y_s2;
    logic signed [SQW-1:0] dx_ext, dy_ext;

    logic [D2W-1:0]       d2;
    logic                 pix_on;
    logic [3:0]           fsm_r, fsm_g, fsm_b;
    logic [3:0]           fg_r, fg_g, fg_b;
    logic                 fg_en;

    assign cnt_wrap = frame_start && (frame_cnt == FC_LAST);

    // Centre only moves at frame boundaries; a pixel on the same cycle still sees the old centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx <= CENTRE_RST;
            cy <= CENTRE_RST;
        end else if (frame_start) begin
            cx <= Centre_X;
            cy <= Centre_Y;
        end
    end

    // Frame counter: counts frame_start pulses, clears when the colour advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (cnt_wrap) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Colour FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RED;
        end else begin
            state <= state_nxt;
        end
    end

    // Colour FSM next state and per-state colour.
    always_comb begin
        state_nxt = state;
        fsm_r     = 4'h0;
        fsm_g     = 4'h0;
        fsm_b     = 4'h0;
        case (state)
            ST_RED: begin
                fsm_r = 4'hF;
                if (cnt_wrap) state_nxt = ST_GREEN;
            end
            ST_GREEN: begin
                fsm_g = 4'hF;
                if (cnt_wrap) state_nxt = ST_BLUE;
            end
            ST_BLUE: begin
                fsm_b = 4'hF;
                if (cnt_wrap) state_nxt = ST_RED;
            end
            default: begin
                state_nxt = ST_RED;
            end
        endcase
    end

    // Stage 1: signed offsets from the latched centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            dx_s1 <= '0;
            dy_s1 <= '0;
        end else begin
            v1    <= pix_valid;
            dx_s1 <= {1'b0, pix_x} - {1'b0, cx};
            dy_s1 <= {1'b0, pix_y} - {1'b0, cy};
        end
    end

    // Sign-extend before squaring so the product is exact at full width.
    assign dx_ext = SQW'($signed(dx_s1));
    assign dy_ext = SQW'($signed(dy_s1));

    // Stage 2: squares (always non-negative, held unsigned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sq_x_s2 <= '0;
            sq_y_s2 <= '0;
        end else begin
            v2      <= v1;
            sq_x_s2 <= unsigned'(dx_ext * dx_ext);
            sq_y_s2 <= unsigned'(dy_ext * dy_ext);
        end
    end

    // Sum gets one extra bit so it can never wrap.
    assign d2 = {1'b0, sq_x_s2} + {1'b0, sq_y_s2};

`ifdef CIRCLE_FILL_EN
    assign pix_on = (d2 <= R_OUT_SQ);
`else
    assign pix_on = (d2 >= R_IN_SQ) && (d2 <= R_OUT_SQ);
`endif

    // Foreground colour chosen by SW at the moment the pixel reaches stage 3.
    always_comb begin
        fg_r  = 4'h0;
        fg_g  = 4'h0;
        fg_b  = 4'h0;
        fg_en = 1'b1;
        case (SW)
            2'b00: begin
                fg_r = fsm_r;
                fg_g = fsm_g;
                fg_b = fsm_b;
            end
            2'b01: begin
                fg_r = 4'hF;
                fg_g = 4'hF;
                fg_b = 4'hF;
            end
            2'b10: begin
                fg_r = 4'hF;
            end
            default: begin
                fg_en = 1'b0;
            end
        endcase
    end

    // Stage 3: output register; RGB stays zero unless the pixel is valid and lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            oRed      <= 4'h0;
            oGreen    <= 4'h0;
            oBlue     <= 4'h0;
        end else begin
            out_valid <= v2;
            if (v2 && pix_on && fg_en) begin
                oRed   <= fg_r;
                oGreen <= fg_g;
                oBlue  <= fg_b;
            end else begin
                oRed   <= 4'h0;
                oGreen <= 4'h0;
                oBlue  <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_circle_pixel_render.sv
// Directed bench for circle_pixel_render: ring geometry, centre latching, colour FSM, SW modes, bubbles and reset.
// Expected values are hand-computed for Radius=150, Line_Width=3 (ring d2 in [21609, 22500]), centre 153,153.
// Observed values are packed as {out_valid, red, green, blue}.
module tb_circle_pixel_render;

    logic       clk;
    logic       rst_n;
    logic [9:0] centre_x, centre_y;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [1:0] sw;
    logic [3:0] o_red, o_green, o_blue;
    logic       out_valid;

    int vectors;
    int miscompares;

`ifdef CIRCLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    localparam logic [12:0] IDLE  = 13'h0000;
    localparam logic [12:0] OFF   = {1'b1, 12'h000};
    localparam logic [12:0] RED   = {1'b1, 4'hF, 4'h0, 4'h0};
    localparam logic [12:0] GREEN = {1'b1, 4'h0, 4'hF, 4'h0};
    localparam logic [12:0] BLUE  = {1'b1, 4'h0, 4'h0, 4'hF};
    localparam logic [12:0] WHITE = {1'b1, 4'hF, 4'hF, 4'hF};

    circle_pixel_render dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Centre_X   (centre_x),
        .Centre_Y   (centre_y),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .SW         (sw),
        .oRed       (o_red),
        .oGreen     (o_green),
        .oBlue      (o_blue),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    // Drives one pixel and returns what the output shows three cycles later.
    task automatic run_pix(input logic [9:0] x, input logic [9:0] y, output logic [12:0] obs);
        @(negedge clk);
        pix_x     = x;
        pix_y     = y;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        obs = {out_valid, o_red, o_green, o_blue};
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {out_valid, o_red, o_green, o_blue};
        vectors++;
        if (obs !== IDLE) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", obs, IDLE);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL reset_first_pixel: got %h expected %h", obs, RED);
        end
    endtask

    task automatic test_latency();
        logic [12:0] obs;
        @(negedge clk);
        pix_x     = 10'd153;
        pix_y     = 10'd3;
        pix_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            obs = {out_valid, o_red, o_green, o_blue};
            vectors++;
            if (obs !== ((k == 3) ? RED : IDLE)) begin
                miscompares++;
                $display("FAIL latency_cycle_%0d: got %h expected %h", k, obs, (k == 3) ? RED : IDLE);
            end
        end
    endtask

    task automatic test_ring_boundaries();
        logic [9:0]  xs  [6] = '{10'd153, 10'd153, 10'd153, 10'd153, 10'd3,   10'd303};
        logic [9:0]  ys  [6] = '{10'd153, 10'd6,   10'd7,   10'd2,   10'd153, 10'd153};
        logic [12:0] exp [6];
        logic [12:0] obs;
        exp[0] = FILL ? RED : OFF;  // centre, d2=0
        exp[1] = RED;               // d2=21609, inner bound
        exp[2] = FILL ? RED : OFF;  // d2=21316, just inside ring
        exp[3] = OFF;               // d2=22801, just outside
        exp[4] = RED;               // dx=-150, outer bound
        exp[5] = RED;               // dx=+150, outer bound
        for (int i = 0; i < 6; i++) begin
            run_pix(xs[i], ys[i], obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL ring_%0d_%0d: got %h expected %h", xs[i], ys[i], obs, exp[i]);
            end
        end
    endtask

    task automatic test_centre_latch();
        logic [12:0] obs;
        centre_x = 10'd300;
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL centre_hold_old: got %h expected %h", obs, RED);
        end
        run_pix(10'd300, 10'd3, obs);
        vectors++;
        if (obs !== OFF) begin
            miscompares++;
            $display("FAIL centre_hold_new_off: got %h expected %h", obs, OFF);
        end
        pulse_frames(1);
        run_pix(10'd300, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL centre_latched_new: got %h expected %h", obs, RED);
        end
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== OFF) begin
            miscompares++;
            $display("FAIL centre_latched_old_off: got %h expected %h", obs, OFF);
        end
        // Pixel on the frame_start cycle must still see centre 300.
        centre_x = 10'd153;
        @(negedge clk);
        frame_start = 1'b1;
        pix_x       = 10'd300;
        pix_y       = 10'd3;
        pix_valid   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        repeat (2) @(negedge clk);
        obs = {out_valid, o_red, o_green, o_blue};
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL centre_same_cycle: got %h expected %h", obs, RED);
        end
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL centre_after_same_cycle: got %h expected %h", obs, RED);
        end
    endtask

    task automatic test_colour_fsm();
        logic [12:0] obs;
        do_reset();
        pulse_frames(31);
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL fsm_31_frames: got %h expected %h", obs, RED);
        end
        pulse_frames(1);
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== GREEN) begin
            miscompares++;
            $display("FAIL fsm_32_frames: got %h expected %h", obs, GREEN);
        end
        pulse_frames(32);
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== BLUE) begin
            miscompares++;
            $display("FAIL fsm_64_frames: got %h expected %h", obs, BLUE);
        end
        pulse_frames(32);
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL fsm_96_frames: got %h expected %h", obs, RED);
        end
    endtask

    task automatic test_sw_select();
        logic [1:0]  modes [5] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
        logic [9:0]  ys    [5] = '{10'd3, 10'd3, 10'd3, 10'd153, 10'd3};
        logic [12:0] exp   [5];
        logic [12:0] obs;
        exp[0] = GREEN;
        exp[1] = RED;
        exp[2] = WHITE;
        exp[3] = FILL ? WHITE : OFF;
        exp[4] = OFF;
        do_reset();
        pulse_frames(32);
        for (int i = 0; i < 5; i++) begin
            sw = modes[i];
            run_pix(10'd153, ys[i], obs);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL sw_%0d_y%0d: got %h expected %h", modes[i], ys[i], obs, exp[i]);
            end
        end
        sw = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic        vl  [6] = '{1'b1,    1'b0,  1'b1,    1'b1,    1'b0,  1'b1};
        logic [9:0]  xs  [6] = '{10'd300, 10'd0, 10'd150, 10'd300, 10'd0, 10'd450};
        logic [9:0]  ys  [6] = '{10'd3,   10'd0, 10'd153, 10'd153, 10'd0, 10'd153};
        logic [12:0] exp [3];
        logic [12:0] obs;
        exp[0] = GREEN;
        exp[1] = IDLE;
        exp[2] = GREEN;
        do_reset();
        centre_x = 10'd300;
        pulse_frames(32);   // centre 300,153 and FSM green
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                obs = {out_valid, o_red, o_green, o_blue};
                vectors++;
                if (obs !== exp[k-3]) begin
                    miscompares++;
                    $display("FAIL stream_slot_%0d: got %h expected %h", k - 3, obs, exp[k-3]);
                end
            end
            pix_valid = vl[k];
            pix_x     = xs[k];
            pix_y     = ys[k];
        end
        // Reset lands while slot 2 (valid green) is on the output.
        #2;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        #1;
        obs = {out_valid, o_red, o_green, o_blue};
        vectors++;
        if (obs !== IDLE) begin
            miscompares++;
            $display("FAIL stream_async_reset: got %h expected %h", obs, IDLE);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_flushed_%0d: got %b expected 0", k, out_valid);
            end
        end
        centre_x = 10'd153;   // no frame_start: centre must come from reset
        run_pix(10'd153, 10'd3, obs);
        vectors++;
        if (obs !== RED) begin
            miscompares++;
            $display("FAIL post_reset_centre_fsm: got %h expected %h", obs, RED);
        end
        run_pix(10'd300, 10'd3, obs);
        vectors++;
        if (obs !== OFF) begin
            miscompares++;
            $display("FAIL post_reset_old_centre_off: got %h expected %h", obs, OFF);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        centre_x    = 10'd153;
        centre_y    = 10'd153;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = 10'd0;
        pix_y       = 10'd0;
        sw          = 2'b00;
        test_reset();
        test_latency();
        test_ring_boundaries();
        test_centre_latch();
        test_colour_fsm();
        test_sw_select();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
